// File: rtl/bpf_sweep_pkg.sv
// Shared types for the band-pass filter sweep sequencer: FSM state encoding
// and the one-hot source-enable codes.
package bpf_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BIAS   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_MEAS1  = 3'd3,
    ST_MEAS2  = 3'd4,
    ST_STEP   = 3'd5
  } state_e;

  localparam logic [1:0] SRC_OFF = 2'b00;
  localparam logic [1:0] SRC_P1  = 2'b01;
  localparam logic [1:0] SRC_P2  = 2'b10;

endpackage

// File: rtl/bpf_sweep_sequencer_settle_timer.sv
// Loadable down-counter used to hold off measurements after a frequency
// change; stops at zero and flags it.
module settle_timer #(
  parameter int SET_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SET_W-1:0] value,
  output logic             zero
);

  logic [SET_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = value;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bpf_sweep_sequencer.sv
// Frequency sweep sequencer: steps the source index, settles, then measures
// port 1 and port 2 at each point. Optional DC bias stage: SWEEP_DC_BIAS_EN.
module bpf_sweep_sequencer
  import bpf_sweep_pkg::*;
#(
  parameter int IDX_W = 12,
  parameter int SET_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] f_start,
  input  logic [IDX_W-1:0] f_stop,
  input  logic [IDX_W-1:0] f_step,
  input  logic [SET_W-1:0] settle,
  input  logic             meas_ack,
  input  logic             bias_ok,
  output logic [IDX_W-1:0] freq_idx,
  output logic [1:0]       src_en,
  output logic             meas_req,
  output logic             bias_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] freq_q, freq_d;
  logic [IDX_W-1:0] stop_q, stop_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [1:0]       src_q, src_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tmr_load, tmr_zero;
  logic [SET_W-1:0] tmr_val;
  logic [IDX_W:0]   nxt;
`ifdef SWEEP_DC_BIAS_EN
  logic             bias_q, bias_d;
`else
  logic             unused_bias_ok;
  assign unused_bias_ok = bias_ok;
`endif

  settle_timer #(.SET_W(SET_W)) u_settle (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // Extra carry bit so a step past the top of the index range ends the sweep.
  assign nxt = {1'b0, freq_q} + {1'b0, step_q};

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    stop_d   = stop_q;
    step_d   = step_q;
    settle_d = settle_q;
    src_d    = src_q;
    req_d    = req_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = settle_q;
`ifdef SWEEP_DC_BIAS_EN
    bias_d   = bias_q;
`endif
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      src_d   = SRC_OFF;
      req_d   = 1'b0;
`ifdef SWEEP_DC_BIAS_EN
      bias_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            if (f_step == '0 || f_start > f_stop) begin
              err_d = 1'b1;
            end else begin
              stop_d   = f_stop;
              step_d   = f_step;
              settle_d = settle;
              freq_d   = f_start;
              busy_d   = 1'b1;
`ifdef SWEEP_DC_BIAS_EN
              bias_d   = 1'b1;
              state_d  = ST_BIAS;
`else
              tmr_load = 1'b1;
              tmr_val  = settle;
              state_d  = ST_SETTLE;
`endif
            end
          end
        end
`ifdef SWEEP_DC_BIAS_EN
        ST_BIAS: begin
          if (bias_ok) begin
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
`endif
        ST_SETTLE: begin
          if (tmr_zero) begin
            src_d   = SRC_P1;
            req_d   = 1'b1;
            state_d = ST_MEAS1;
          end
        end
        ST_MEAS1: begin
          if (meas_ack) begin
            src_d   = SRC_P2;
            state_d = ST_MEAS2;
          end
        end
        ST_MEAS2: begin
          if (meas_ack) begin
            src_d   = SRC_OFF;
            req_d   = 1'b0;
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          if (nxt[IDX_W] || nxt[IDX_W-1:0] > stop_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            src_d   = SRC_OFF;
`ifdef SWEEP_DC_BIAS_EN
            bias_d  = 1'b0;
`endif
            state_d = ST_IDLE;
          end else begin
            freq_d   = nxt[IDX_W-1:0];
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      freq_q   <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      settle_q <= '0;
      src_q    <= SRC_OFF;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef SWEEP_DC_BIAS_EN
      bias_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      src_q    <= src_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef SWEEP_DC_BIAS_EN
      bias_q   <= bias_d;
`endif
    end
  end

  assign freq_idx = freq_q;
  assign src_en   = src_q;
  assign meas_req = req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
`ifdef SWEEP_DC_BIAS_EN
  assign bias_en  = bias_q;
`else
  assign bias_en  = 1'b0;
`endif

endmodule

// File: tb/tb_bpf_sweep_sequencer.sv
// Scoreboarded bench for bpf_sweep_sequencer: expected (freq, port) pairs are
// queued per sweep and popped on each acknowledged measurement.
module tb_bpf_sweep_sequencer;

  localparam int IDX_W = 12;
  localparam int SET_W = 8;
`ifdef SWEEP_DC_BIAS_EN
  localparam int BIAS_CYC = 1;
`else
  localparam int BIAS_CYC = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0;
  logic [IDX_W-1:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [SET_W-1:0] settle = '0;
  logic             meas_ack = 1'b0;
  logic             bias_ok = 1'b1;
  logic [IDX_W-1:0] freq_idx;
  logic [1:0]       src_en;
  logic             meas_req, bias_en, busy, done, err;

  typedef struct { int f; logic [1:0] s; } exp_t;
  exp_t q[$];

  int  n_cmp = 0, n_bad = 0;
  int  ack_delay = 1;
  bit  ack_hold = 0;
  int  age = 0;
  logic [1:0] last_src = 2'b00;
  int  done_cnt = 0, err_cnt = 0, meas_cnt = 0;
  bit  bias_seen = 0;

  bpf_sweep_sequencer #(.IDX_W(IDX_W), .SET_W(SET_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .settle(settle),
    .meas_ack(meas_ack), .bias_ok(bias_ok), .freq_idx(freq_idx),
    .src_en(src_en), .meas_req(meas_req), .bias_en(bias_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Measurement-engine model plus scoreboard compare on every accepted ack.
  always @(negedge clk) begin
    exp_t e;
    if (!meas_req || src_en != last_src) age = 0;
    else age++;
    last_src = src_en;
    meas_ack = ack_hold || (meas_req && age >= ack_delay);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (bias_en) bias_seen = 1;
    if (busy) begin
      n_cmp++;
      if (src_en === 2'b11) begin
        n_bad++; $display("FAIL src_onehot: got %b, required not 11", src_en);
      end
    end
    if (meas_req && meas_ack) begin
      meas_cnt++;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++; $display("FAIL sb_unexpected_meas: freq %0d src %b, none expected", freq_idx, src_en);
      end else begin
        e = q.pop_front();
        if (freq_idx !== e.f[IDX_W-1:0] || src_en !== e.s) begin
          n_bad++;
          $display("FAIL sb_meas: got freq %0d src %b, required freq %0d src %b", freq_idx, src_en, e.f, e.s);
        end
      end
    end
  end

  task automatic start_sweep(input int fs, input int fe, input int st, input int se);
    f_start = fs[IDX_W-1:0]; f_stop = fe[IDX_W-1:0];
    f_step = st[IDX_W-1:0];  settle = se[SET_W-1:0];
    for (int f = fs; f <= fe; f += st) begin
      q.push_back('{f, 2'b01});
      q.push_back('{f, 2'b10});
    end
    done_cnt = 0; meas_cnt = 0; err_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_rise: got %b, required 1", busy);
    end
  endtask

  // Counts busy cycles (the start edge included) until busy drops.
  task automatic wait_idle(output int cyc);
    cyc = 1;
    while (cyc < 3000) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
    end
    #1;
    if (cyc >= 3000) begin
      n_cmp++; n_bad++; $display("FAIL timeout: busy still %b, required 0", busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({freq_idx, src_en, meas_req, bias_en, busy, done, err} !== '0) begin
      n_bad++; $display("FAIL reset_vals: freq %0d src %b req %b bias %b busy %b done %b err %b, required all 0",
                        freq_idx, src_en, meas_req, bias_en, busy, done, err);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic;
    int cyc;
    ack_hold = 0; ack_delay = 1;
    start_sweep(10, 30, 10, 3);
    wait_idle(cyc);
    n_cmp++;
    if (done_cnt !== 1 || meas_cnt !== 6 || freq_idx !== 12'd30 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_end: done %0d meas %0d freq %0d busy %b, required 1 6 30 0",
                        done_cnt, meas_cnt, freq_idx, busy);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL basic_sb_left: %0d entries, required 0", q.size());
    end
  endtask

  task automatic test_err;
    int stp[2] = '{0, 10};
    int sta[2] = '{10, 40};
    for (int i = 0; i < 2; i++) begin
      f_start = sta[i][IDX_W-1:0]; f_stop = 12'd30; f_step = stp[i][IDX_W-1:0];
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        n_bad++; $display("FAIL err_pulse%0d: err %b busy %b, required 1 0", i, err, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL err_single%0d: err %b busy %b, required 0 0", i, err, busy);
      end
    end
  endtask

  task automatic test_overflow;
    int cyc;
    ack_hold = 0; ack_delay = 1;
    start_sweep(4090, 4095, 4, 1);
    wait_idle(cyc);
    n_cmp++;
    if (done_cnt !== 1 || meas_cnt !== 4 || freq_idx !== 12'd4094 || q.size() != 0) begin
      n_bad++; $display("FAIL overflow_end: done %0d meas %0d freq %0d left %0d, required 1 4 4094 0",
                        done_cnt, meas_cnt, freq_idx, q.size());
    end
  endtask

  task automatic test_abort;
    int n = 0;
    ack_hold = 0; ack_delay = 1;
    start_sweep(10, 30, 10, 1);
    while (!(src_en == 2'b10 && freq_idx == 12'd20) && n < 500) begin
      @(negedge clk); n++;
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || meas_req !== 1'b0 || src_en !== 2'b00 || bias_en !== 1'b0 || freq_idx !== 12'd20) begin
      n_bad++; $display("FAIL abort_state: busy %b req %b src %b bias %b freq %0d, required 0 0 00 0 20",
                        busy, meas_req, src_en, bias_en, freq_idx);
    end
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (done_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_quiet: done %0d err %0d busy %b, required 0 0 0", done_cnt, err_cnt, busy);
    end
    q.delete();
  endtask

  task automatic test_point_timing;
    int cyc;
    ack_hold = 1;
    start_sweep(5, 5, 1, 0);
    wait_idle(cyc);
    n_cmp++;
    if (cyc !== 4 + BIAS_CYC || done_cnt !== 1 || meas_cnt !== 2) begin
      n_bad++; $display("FAIL point_timing: cycles %0d done %0d meas %0d, required %0d 1 2",
                        cyc, done_cnt, meas_cnt, 4 + BIAS_CYC);
    end
    ack_hold = 0;
  endtask

  task automatic test_back_to_back;
    int cyc;
    ack_hold = 1;
    start_sweep(0, 2, 1, 2);
    wait_idle(cyc);
    n_cmp++;
    if (cyc !== 18 + BIAS_CYC || done_cnt !== 1 || freq_idx !== 12'd2) begin
      n_bad++; $display("FAIL b2b_first: cycles %0d done %0d freq %0d, required %0d 1 2",
                        cyc, done_cnt, freq_idx, 18 + BIAS_CYC);
    end
    // Second sweep straight away; a mid-sweep start with a bad config is ignored.
    start_sweep(7, 8, 1, 1);
    repeat (3) @(negedge clk);
    f_start = 12'd100; f_stop = 12'd1; f_step = 12'd0;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle(cyc);
    n_cmp++;
    if (done_cnt !== 1 || err_cnt !== 0 || meas_cnt !== 4 || freq_idx !== 12'd8 || q.size() != 0) begin
      n_bad++; $display("FAIL b2b_second: done %0d err %0d meas %0d freq %0d left %0d, required 1 0 4 8 0",
                        done_cnt, err_cnt, meas_cnt, freq_idx, q.size());
    end
    ack_hold = 0;
  endtask

  task automatic test_start_abort_same;
    f_start = 12'd1; f_stop = 12'd2; f_step = 12'd1;
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL start_abort: busy %b err %b, required 0 0", busy, err);
    end
  endtask

  task automatic test_bias;
`ifdef SWEEP_DC_BIAS_EN
    int cyc;
    int req_seen = 0;
    bias_ok = 1'b0;
    start_sweep(3, 3, 1, 0);
    repeat (50) begin
      @(negedge clk);
      if (meas_req) req_seen++;
    end
    n_cmp++;
    if (bias_en !== 1'b1 || req_seen !== 0) begin
      n_bad++; $display("FAIL bias_wait: bias_en %b req_cycles %0d, required 1 0", bias_en, req_seen);
    end
    bias_ok = 1'b1;
    wait_idle(cyc);
    n_cmp++;
    if (done_cnt !== 1 || meas_cnt !== 2 || bias_en !== 1'b0) begin
      n_bad++; $display("FAIL bias_end: done %0d meas %0d bias_en %b, required 1 2 0", done_cnt, meas_cnt, bias_en);
    end
`else
    n_cmp++;
    if (bias_seen !== 1'b0) begin
      n_bad++; $display("FAIL bias_tied: bias_en seen %b, required 0", bias_seen);
    end
`endif
  endtask

  task automatic test_async_reset;
    int cyc;
    ack_hold = 0; ack_delay = 1;
    start_sweep(50, 90, 10, 2);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({freq_idx, src_en, meas_req, busy} !== '0) begin
      n_bad++; $display("FAIL async_reset: freq %0d src %b req %b busy %b, required 0 00 0 0",
                        freq_idx, src_en, meas_req, busy);
    end
    @(negedge clk) rst = 1'b0;
    q.delete();
    start_sweep(1, 1, 1, 0);
    wait_idle(cyc);
    n_cmp++;
    if (done_cnt !== 1 || meas_cnt !== 2 || freq_idx !== 12'd1) begin
      n_bad++; $display("FAIL after_reset: done %0d meas %0d freq %0d, required 1 2 1", done_cnt, meas_cnt, freq_idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_overflow();
    test_abort();
    test_point_timing();
    test_back_to_back();
    test_start_abort_same();
    test_bias();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
